// File: rtl/fft_butterfly_pipe.sv
// Radix-2 DIT butterfly engine for the 16-point FFT datapath.
// Derives the twiddle address from (stage, index) and drives it to a
// combinational twiddle ROM. The returned W16^k is applied, and the engine
// produces X = (A + B*W)/2 and Y = (A - B*W)/2. The results pass through a
// 3-stage valid/ready pipeline and are saturated on output.
// Optional feature macro: FFT_BFLY_UNITY_BYPASS_EN. When it is defined,
// k == 0 uses an exact W = +1 instead of the ROM word.
module fft_butterfly_pipe #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   in_a,
    input  logic [2*DATA_W-1:0]   in_b,
    input  logic [1:0]            in_stage,
    input  logic [2:0]            in_idx,
    output logic [2:0]            twiddle_addr,
    input  logic [2*DATA_W-1:0]   twiddle,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_x,
    output logic [2*DATA_W-1:0]   out_y,
    output logic                  out_sat
);

    localparam int PW   = 2 * DATA_W;     // product / packed operand width
    localparam int SW   = DATA_W + 4;     // butterfly sum width
    localparam int FRAC = DATA_W - 1;     // twiddle fractional bits (Q1.7)
    localparam int MAXI = (1 << (DATA_W - 1)) - 1;
    localparam logic signed [SW-1:0] MAXV = SW'(MAXI);
    localparam logic signed [SW-1:0] MINV = SW'(-MAXI - 1);
    localparam logic [DATA_W-1:0] POS_LIM = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_LIM = {1'b1, {(DATA_W-1){1'b0}}};

    // Stage 1: operands and twiddle index
    logic            r_s1_valid;
    logic [PW-1:0]   r_s1_a;
    logic [PW-1:0]   r_s1_b;
    logic [2:0]      r_s1_k;

    // Stage 2: operand A and the four partial products
    logic                   r_s2_valid;
    logic [PW-1:0]          r_s2_a;
    logic signed [PW-1:0]   r_p_rr;
    logic signed [PW-1:0]   r_p_ii;
    logic signed [PW-1:0]   r_p_ri;
    logic signed [PW-1:0]   r_p_ir;

    // Output stage
    logic            r_out_valid;
    logic [PW-1:0]   r_out_x;
    logic [PW-1:0]   r_out_y;
    logic            r_out_sat;

    logic            w_advance;
    logic [2:0]      w_mask;
    logic [2:0]      w_k;

    // The whole pipeline moves as one unit. It stalls only when a result is waiting.
    assign w_advance    = !r_out_valid || out_ready;
    assign in_ready     = w_advance;
    assign twiddle_addr = r_s1_k;
    assign out_valid    = r_out_valid;
    assign out_x        = r_out_x;
    assign out_y        = r_out_y;
    assign out_sat      = r_out_sat;

    // k = (j & ((1<<s)-1)) << (3-s). The 3-bit mask wraps to 7 when s = 3.
    assign w_mask = (3'd1 << in_stage) - 3'd1;
    assign w_k    = (in_idx & w_mask) << (2'd3 - in_stage);

    // ---------------- Stage 2 product formation ----------------
    logic signed [DATA_W-1:0] w_br, w_bi, w_wr, w_wi;
    logic                     w_unity;
    logic signed [PW-1:0]     w_p_rr, w_p_ii, w_p_ri, w_p_ir;

    assign w_br = $signed(r_s1_b[PW-1:DATA_W]);
    assign w_bi = $signed(r_s1_b[DATA_W-1:0]);
    assign w_wr = $signed(twiddle[PW-1:DATA_W]);
    assign w_wi = $signed(twiddle[DATA_W-1:0]);

`ifdef FFT_BFLY_UNITY_BYPASS_EN
    assign w_unity = (r_s1_k == 3'd0);
`else
    assign w_unity = 1'b0;
`endif

    // Form the full-width products. With unity bypass, W = +1 exactly, so B passes through scaled by 2^FRAC.
    always_comb begin
        w_p_rr = PW'(w_br) * PW'(w_wr);
        w_p_ii = PW'(w_bi) * PW'(w_wi);
        w_p_ri = PW'(w_br) * PW'(w_wi);
        w_p_ir = PW'(w_bi) * PW'(w_wr);
        if (w_unity) begin
            w_p_rr = PW'(w_br) <<< FRAC;
            w_p_ii = '0;
            w_p_ri = '0;
            w_p_ir = PW'(w_bi) <<< FRAC;
        end
    end

    // ---------------- Stage 3 butterfly and saturation ----------------
    logic signed [PW:0]   w_re_acc, w_im_acc, w_re_sh, w_im_sh;
    logic signed [SW-1:0] w_a_ext [2];
    logic signed [SW-1:0] w_bw    [2];
    logic [DATA_W-1:0]    w_res   [4];
    logic [3:0]           w_sat;

    assign w_re_acc = (PW+1)'(r_p_rr) - (PW+1)'(r_p_ii);
    assign w_im_acc = (PW+1)'(r_p_ri) + (PW+1)'(r_p_ir);
    assign w_re_sh  = w_re_acc >>> FRAC;
    assign w_im_sh  = w_im_acc >>> FRAC;
    assign w_bw[0]  = SW'(w_re_sh);
    assign w_bw[1]  = SW'(w_im_sh);
    assign w_a_ext[0] = SW'($signed(r_s2_a[PW-1:DATA_W]));
    assign w_a_ext[1] = SW'($signed(r_s2_a[DATA_W-1:0]));

    // The four result components are {Xre, Xim, Yre, Yim}. Each is halved by an arithmetic shift and then clamped.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_comp
            logic signed [SW-1:0] w_sum;
            logic signed [SW-1:0] w_half;
            if (gi < 2) begin : g_add
                assign w_sum = w_a_ext[gi] + w_bw[gi];
            end else begin : g_sub
                assign w_sum = w_a_ext[gi-2] - w_bw[gi-2];
            end
            assign w_half    = w_sum >>> 1;
            assign w_sat[gi] = (w_half > MAXV) || (w_half < MINV);
            assign w_res[gi] = w_sat[gi] ? (w_half[SW-1] ? NEG_LIM : POS_LIM)
                                         : w_half[DATA_W-1:0];
        end
    endgenerate

    // Pipeline registers. All of them load together on advance and hold together on stall. Reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_k      <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_a      <= '0;
            r_p_rr      <= '0;
            r_p_ii      <= '0;
            r_p_ri      <= '0;
            r_p_ir      <= '0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid  <= in_valid;
            r_s1_a      <= in_a;
            r_s1_b      <= in_b;
            r_s1_k      <= w_k;
            r_s2_valid  <= r_s1_valid;
            r_s2_a      <= r_s1_a;
            r_p_rr      <= w_p_rr;
            r_p_ii      <= w_p_ii;
            r_p_ri      <= w_p_ri;
            r_p_ir      <= w_p_ir;
            r_out_valid <= r_s2_valid;
            r_out_x     <= {w_res[0], w_res[1]};
            r_out_y     <= {w_res[2], w_res[3]};
            r_out_sat   <= |w_sat;
        end
    end

endmodule

// File: doc/fft_butterfly_pipe.md
Name: fft_butterfly_pipe

Overview:
- Radix-2 DIT butterfly engine for the 16-point FFT datapath; the consumer (read side) of the packed twiddle ROM interface.
- Takes a complex operand pair (A, B) plus stage/butterfly index, derives the twiddle address, drives it to the combinational twiddle ROM, and applies the returned W16^k.
- Outputs X = (A + B·W)/2 and Y = (A − B·W)/2 through a 3-stage valid/ready pipeline with saturation.

Parameters:
- DATA_W, 8, width of each signed real/imag component of operands, results and twiddle halves; twiddle halves are Q1.7.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  pipeline can accept.
- in_a  in  2*DATA_W  packed {re, im}, signed.
- in_b  in  2*DATA_W  packed {re, im}, signed.
- in_stage  in  2  FFT stage s, 0..3.
- in_idx  in  3  butterfly index j, 0..7.
- twiddle_addr  out  3  address k to the twiddle ROM.
- twiddle  in  2*DATA_W  ROM data {re[15:8], im[7:0]}, each signed Q1.7; combinational response to twiddle_addr.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_x  out  2*DATA_W  {re, im} of (A+BW)>>1.
- out_y  out  2*DATA_W  {re, im} of (A−BW)>>1.
- out_sat  out  1  any of the four result components saturated.

Behaviour:
- Reset (synchronous, active-high): all stage valid bits 0; out_valid=0, out_x=0, out_y=0, out_sat=0, twiddle_addr=0. in_ready follows its equation. Reset mid-operation discards in-flight data with no partial output.
- Advance = !out_valid || out_ready. in_ready = advance. All pipeline registers load only on advance; on stall, every register holds, including twiddle_addr.
- Transfer in at an edge with in_valid && in_ready. Transfer out at an edge with out_valid && out_ready.
- k = (j & ((1<<s)−1)) << (3−s), truncated to 3 bits. Examples: s=0 gives k=0; s=3 gives k=j.
- S1 (registered at accept): A, B, k, valid. twiddle_addr = S1.k.
- S2: samples twiddle. Registers four products, each full 2*DATA_W signed: Br·Wr, Bi·Wi, Br·Wi, Bi·Wr.
- S3 / output stage:
  - BWre = (Br·Wr − Bi·Wi) >>> 7.
  - BWim = (Br·Wi + Bi·Wr) >>> 7.
  - Arithmetic shifts, truncation toward −inf.
  - X = (A + BW) >>> 1 and Y = (A − BW) >>> 1, computed at DATA_W+4 width, then each component saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - out_sat = OR of the four saturation events.
- Latency: operand accepted at the end of cycle c gives out_valid in cycle c+3. Throughput is 1 per cycle with out_ready held high.
- Twiddle 0x80 half reads as −1.0 (−128). No special decoding of ROM data except under the optional feature.
- Back-to-back inputs with differing k: each result uses its own k; no cross-contamination across stalls.

Optional Feature:
- FFT_BFLY_UNITY_BYPASS_EN.
- Defined: when S1.k==0, S2 ignores twiddle and uses exact W = +1+j0; products become Br·128, Bi·128, 0, 0. This makes the k=0 ROM entry 0x8000 mean +1, not −1. twiddle_addr is still driven.
- Undefined: ROM value used raw for all k, so k=0 applies −1.

Test Plan:
- Reset, then A=(10,0), B=(20,0), s=0, j=0; X=(15,0), Y=(−5,0) with the macro; X=(−5,0), Y=(15,0) without. twiddle_addr=0. out_valid three cycles after accept.
- s=3, j=2 (k=2, W=0x0080), A=(0,0), B=(64,0) → X=(0,−32), Y=(0,32).
- s=3, j=1 (k=1, W=0x5AA6), A=(0,0), B=(100,0) → X=(35,−36), Y=(−35,35); checks truncation toward −inf.
- s=3, j=1, A=(−128,0), B=(−128,−128) → X=(−128,0) with out_sat=1, Y=(26,0).
- Stream 8 pairs at s=2, j=0..7 with out_ready toggling 1,0,0,1 → twiddle_addr sequence 0,2,4,6,0,2,4,6. Outputs in order; none lost or duplicated; in_ready=0 exactly when out_valid && !out_ready.
- rst asserted with 3 items in flight → next cycle out_valid=0, outputs 0. First post-reset input emerges after exactly 3 cycles.
